// File: rtl/uart_rx_stream.sv
// uart_rx_stream: UART receiver (start-glitch, framing and overrun detection) feeding a valid/ready FIFO.
// Build option: define UART_RX_PARITY_EN for 8E1 frames; the default build receives 8N1.
module uart_rx_stream #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_AW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [FIFO_AW:0] fifo_level,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);
  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CW    = $clog2(CPB);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(CPB - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ZERO = '0;
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW + 1)'(1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx_stream: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  // state  | meaning
  // idle   | line idle, waiting for a falling edge
  // start  | timing to mid start bit to reject glitches
  // data   | shifting in 8 data bits, LSB first
  // parity | sampling the even-parity bit (parity build only)
  // stop   | sampling the stop bit, then push or flag an error
  typedef enum logic [2:0] {st_idle, st_start, st_data, st_parity, st_stop} state_t;

  state_t          state, state_nxt;
  logic            sync1, rx_s, rx_p;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shreg, sh_nxt;
  logic            push, ferr_set, perr_set, par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_p  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      rx_p  <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_bit <= 1'b0;
    else if (state == st_parity && cnt == CNT_LAST)
      par_bit <= rx_s;
  end

  assign par_bad = par_bit ^ (^shreg);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= st_idle;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    case (state)
      st_idle: begin
        cnt_nxt = '0;
        if (rx_p && !rx_s) state_nxt = st_start;
      end
      st_start: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? st_idle : st_data;
        end
      end
      st_data: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, shreg[7:1]};
          bit_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = st_parity;
`else
            state_nxt = st_stop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      st_parity: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = st_stop;
        end
      end
`endif
      st_stop: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = st_idle;
          // a bad stop bit outranks a parity mismatch so only one pulse fires
          if (!rx_s)        ferr_set = 1'b1;
          else if (par_bad) perr_set = 1'b1;
          else              push     = 1'b1;
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  assign busy = (state != st_idle);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               pop, full, wr;

  assign rx_valid   = (count != LVL_ZERO);
  assign fifo_level = count;
  assign pop        = rx_valid & rx_ready;
  assign full       = (count == LVL_FULL);
  assign wr         = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= ferr_set;
      parity_err <= perr_set;
      overrun    <= push & full & ~pop;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // head register: bypass the incoming byte when it becomes the new head
      if (wr && (count == LVL_ZERO || (pop && count == LVL_ONE)))
        rx_data <= shreg;
      else if (pop && count > LVL_ONE)
        rx_data <= mem[rptr + 1'b1];
    end
  end
endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: directed and randomized frames against a queue-based model of the receiver.
// Compile with UART_RX_PARITY_EN defined to exercise 8E1 frames.
module tb_uart_rx_stream;
  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int FIFO_AW   = 2;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;
  localparam int DEPTH     = 1 << FIFO_AW;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = PAR_EN ? 11 : 10;
  // start edge drive -> 2 sync flops -> edge detect, then half a bit plus the remaining bits
  localparam int LAT = 3 + HALF + (NBITS - 1) * CPB;

  logic             clk, rst_n, rx, rx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid, busy, frame_err, parity_err, overrun;
  logic [FIFO_AW:0] fifo_level;

  uart_rx_stream #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .fifo_level(fifo_level),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int fe_seen = 0, pe_seen = 0, ov_seen = 0, multi_seen = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_pop[$];
  logic [7:0] popped[$];

  always @(negedge clk) begin
    if (frame_err)  fe_seen++;
    if (parity_err) pe_seen++;
    if (overrun)    ov_seen++;
    if ((int'(frame_err) + int'(parity_err) + int'(overrun)) > 1) multi_seen++;
    if (rst_n && rx_valid && rx_ready) popped.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // line stays at the stop-bit level afterwards; callers restore idle
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (PAR_EN) b.push_back((^d) ^ par_flip);
    b.push_back(~stop_bad);
    foreach (b[i]) begin
      rx = b[i];
      repeat (CPB) tick();
    end
  endtask

  // outcome of one frame received while nothing is popping
  task automatic model_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad);
    if (stop_bad)                    exp_fe++;
    else if (PAR_EN && par_flip)     exp_pe++;
    else if (exp_q.size() == DEPTH)  exp_ov++;
    else                             exp_q.push_back(d);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    chk({tag, "_frame_err"}, 32'(fe_seen), 32'(exp_fe));
    chk({tag, "_parity_err"}, 32'(pe_seen), 32'(exp_pe));
    chk({tag, "_overrun"}, 32'(ov_seen), 32'(exp_ov));
    chk({tag, "_pulse_overlap"}, 32'(multi_seen), 32'(0));
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    rx_ready = 1'b0;
    tick();
    while (exp_q.size() > 0) exp_pop.push_back(exp_q.pop_front());
    chk({tag, "_pop_count"}, 32'(popped.size()), 32'(exp_pop.size()));
    for (int i = 0; i < exp_pop.size() && i < popped.size(); i++)
      chk({tag, "_pop_byte"}, 32'(popped[i]), 32'(exp_pop[i]));
    chk({tag, "_drained_level"}, 32'(fifo_level), 32'(0));
    chk({tag, "_drained_valid"}, 32'(rx_valid), 32'(0));
    popped.delete();
    exp_pop.delete();
  endtask

  initial begin
    int n0;
    logic [7:0] d;
    bit pf, sb;

    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_data", 32'(rx_data), 32'(0));
    chk("rst_valid", 32'(rx_valid), 32'(0));
    chk("rst_level", 32'(fifo_level), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pulses", 32'({frame_err, parity_err, overrun}), 32'(0));
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_busy", 32'(busy), 32'(0));

    // single byte with consumer ready, exact push latency
    rx_ready = 1'b1;
    n0 = cyc;
    fork
      send_frame(8'h55, 1'b0, 1'b0);
      begin
        while (cyc < n0 + LAT - 1) @(negedge clk);
        chk("t1_valid_early", 32'(rx_valid), 32'(0));
        @(negedge clk);
        chk("t1_valid", 32'(rx_valid), 32'(1));
        chk("t1_data", 32'(rx_data), 32'(8'h55));
        @(negedge clk);
        chk("t1_popped_valid", 32'(rx_valid), 32'(0));
        chk("t1_popped_level", 32'(fifo_level), 32'(0));
      end
    join
    rx = 1'b1;
    repeat (10) tick();
    rx_ready = 1'b0;
    exp_pop.push_back(8'h55);
    check_status("t1");
    drain("t1");

    // start-bit glitch
    rx = 1'b0;
    repeat (3) tick();
    chk("t2_busy_glitch", 32'(busy), 32'(1));
    rx = 1'b1;
    repeat (20) tick();
    chk("t2_busy_after", 32'(busy), 32'(0));
    check_status("t2");

    // framing error, line left low
    send_frame(8'hA3, 1'b0, 1'b1);
    repeat (200) tick();
    model_frame(8'hA3, 1'b0, 1'b1);
    chk("t3_busy_low_line", 32'(busy), 32'(0));
    check_status("t3");
    rx = 1'b1;
    repeat (20) tick();

    // fill and overrun
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, 1'b0, 1'b0);
      rx = 1'b1;
      repeat (5) tick();
      model_frame(d, 1'b0, 1'b0);
      check_status("t4_fill");
    end
    drain("t4");

    // full FIFO: push and pop on the same edge
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'h11 + 8'(i);
      send_frame(d, 1'b0, 1'b0);
      rx = 1'b1;
      repeat (5) tick();
      model_frame(d, 1'b0, 1'b0);
    end
    n0 = cyc;
    fork
      send_frame(8'h99, 1'b0, 1'b0);
      begin
        while (cyc < n0 + LAT - 1) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    rx = 1'b1;
    repeat (5) tick();
    exp_pop.push_back(exp_q.pop_front());
    exp_q.push_back(8'h99);
    check_status("t4_pushpop");
    drain("t4_pushpop");

    // reset mid-frame with bytes queued
    for (int i = 0; i < 2; i++) begin
      d = 8'h21 + 8'(i);
      send_frame(d, 1'b0, 1'b0);
      rx = 1'b1;
      repeat (5) tick();
      model_frame(d, 1'b0, 1'b0);
    end
    check_status("t5_queued");
    d = 8'h3C;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
    rx = d[4];
    repeat (HALF) tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_data", 32'(rx_data), 32'(0));
    chk("t5_rst_valid", 32'(rx_valid), 32'(0));
    chk("t5_rst_level", 32'(fifo_level), 32'(0));
    chk("t5_rst_busy", 32'(busy), 32'(0));
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    exp_q.delete();
    exp_pop.delete();
    popped.delete();
    send_frame(d, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (10) tick();
    model_frame(d, 1'b0, 1'b0);
    check_status("t5_after");
    drain("t5");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (5) tick();
    model_frame(8'h07, 1'b0, 1'b0);
    check_status("t6_good_parity");
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (5) tick();
    model_frame(8'h07, 1'b1, 1'b0);
    check_status("t6_bad_parity");
    drain("t6");
`endif

    // randomized frames, glitches and gaps
    for (int r = 0; r < 8; r++) begin
      int nf;
      nf = int'($urandom_range(1, 6));
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 3) == 0) begin
          rx = 1'b0;
          repeat ($urandom_range(1, HALF - 2)) tick();
          rx = 1'b1;
          repeat (15) tick();
        end
        d  = 8'($urandom);
        pf = ($urandom_range(0, 4) == 0);
        sb = ($urandom_range(0, 7) == 0);
        send_frame(d, pf, sb);
        rx = 1'b1;
        repeat ($urandom_range(1, 12)) tick();
        model_frame(d, pf, sb);
      end
      check_status("rand");
      drain("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
